// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// State encodings, requester count and a one-hot helper.
package mux_rr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle of the round-robin mux arbiter.
// The arbiter uses the master modport; requesters and the sink use slave.
interface mux_rr_arbiter_if
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DW = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    last;
    logic [NREQ*DW-1:0] in_data;
    logic               out_ready;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         sel;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               busy;

    modport master (
        input  req, last, in_data, out_ready,
        output gnt, sel, out_valid, out_data, busy
    );

    modport slave (
        output req, last, in_data, out_ready,
        input  gnt, sel, out_valid, out_data, busy
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set req bit from ptr upward.
// Zero latency; no flow control of its own.
// idx is meaningless when any is low.
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            any,
    output logic [1:0]      idx
);
    logic [1:0] cand;

    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        // Walk from the farthest offset down so the nearest one overrides.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 data mux; grant held until last beat or MAX_BEATS.
// Request-to-grant 1 cycle, one idle cycle after each release; data path is combinational.
// out_ready low stalls the owner indefinitely with count and grant held.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.master bus
);
    arb_state_t      state_q, state_n;
    logic [1:0]      ptr_q, ptr_n;
    logic [1:0]      sel_q, sel_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [7:0]      cnt_q, cnt_n;

    logic       pick_any;
    logic [1:0] pick_idx;
    logic       beat;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign bus.out_valid = (state_q == GRANT) && bus.req[sel_q];
    assign beat          = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.in_data[sel_q*DW +: DW];
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            sel_q   <= sel_n;
            gnt_q   <= gnt_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        sel_n   = sel_q;
        gnt_n   = gnt_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    gnt_n   = onehot4(pick_idx);
                    cnt_n   = 8'd0;
                end
            end
            GRANT: begin
                // An aborted request releases without counting a beat.
                if (!bus.req[sel_q] ||
                    (beat && (bus.last[sel_q] || (cnt_q + 8'd1 == 8'(MAX_BEATS))))) begin
                    state_n = IDLE;
                    ptr_n   = sel_q + 2'd1;
                    gnt_n   = '0;
                    cnt_n   = 8'd0;
                end else if (beat) begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
